melody_player: RTL and testbench
================================

Name: melody_player

Overview:
- Parametrised successor to the fixed note-divider lookup.
- A writable note table holds one divider per note slot. The playback engine steps through the table at a programmable slot length, with one-shot or loop mode.
- An integrated tone generator produces a square wave from the current divider. Divider 0 marks a rest.
- Sits between the host/config logic and the audio output pin.

Parameters:
- BW, 16, divider width in bits; half-period in clock cycles.
- IDX_W, 5, note index width; table depth is 2**IDX_W entries.
- LEN_W, 24, width of the note-slot length field.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous active-low reset.
- wr_en_i  in  1  table write strobe.
- wr_addr_i  in  IDX_W  table write address.
- wr_data_i  in  BW  divider value to write; 0 = rest.
- start_i  in  1  start playback; level sampled each cycle.
- stop_i  in  1  abort playback.
- loop_i  in  1  loop mode; captured at start.
- last_idx_i  in  IDX_W  index of the final note; captured at start.
- note_len_i  in  LEN_W  note slot length minus 1, in cycles; captured at start.
- wave_o  out  1  square-wave audio output.
- busy_o  out  1  high while in PLAY.
- done_o  out  1  one-cycle pulse at natural end of a one-shot melody.
- note_idx_o  out  IDX_W  index currently playing.
- note_active_o  out  1  PLAY and current divider != 0.

Behaviour:
- Reset, synchronous on rst_n_i=0 at the clock edge:
  - state IDLE.
  - All table entries 0.
  - idx, slot_cnt, tone_cnt = 0.
  - All captured config = 0.
  - All outputs 0.
  - Reset mid-playback aborts immediately, with no done_o pulse.
- Table writes:
  - Accepted only in IDLE; written on the edge where wr_en_i=1.
  - Ignored (table unchanged) in PLAY.
  - Table read is combinational from the register array: D = table[idx].
- FSM, states IDLE and PLAY.
  - IDLE -> PLAY when start_i=1 and stop_i=0. On that edge:
    - Capture loop_i, last_idx_i, note_len_i.
    - idx=0, slot_cnt=0, tone_cnt=0, wave=0.
    - busy_o=1 from the next cycle.
  - PLAY -> IDLE when stop_i=1. Next cycle: busy_o=0, wave_o=0, done_o=0. stop_i has priority over all other events.
  - start_i while in PLAY is ignored; no restart.
- Slot timing, in PLAY:
  - slot_cnt increments every cycle.
  - When slot_cnt == len_q: slot_cnt <= 0, tone_cnt <= 0, wave <= 0 (each note starts phase-aligned low). Then:
    - If idx != last_q: idx <= idx+1.
    - Else if loop_q: idx <= 0 and stay in PLAY.
    - Else: go to IDLE, assert done_o for exactly that next cycle, idx <= 0.
  - Each note lasts len_q+1 cycles. len_q=0 gives one cycle per note.
  - last_q = 2**IDX_W-1 plays the full table. idx wraps naturally.
- Tone generation, in PLAY, not at a slot boundary:
  - D == 0: wave=0, tone_cnt held at 0.
  - D != 0: tone_cnt increments. When tone_cnt == D-1: tone_cnt <= 0 and wave toggles.
  - Result: half-period D cycles, frequency f_clk/(2*D). D=1 toggles every cycle.
- Outputs:
  - wave_o is registered and forced 0 in IDLE.
  - note_idx_o = idx.
  - note_active_o is combinational from state and D.
- Arithmetic:
  - All counters unsigned.
  - tone_cnt is BW bits and never exceeds D-1.
  - slot_cnt is LEN_W bits and never exceeds len_q.
  - No overflow paths.

Test Plan:
- Write table[0]=4, table[1]=0, table[2]=2; start with last_idx=2, note_len=15, loop=0:
  - Slot 0: wave toggles every 4 cycles.
  - Slot 1: wave=0, note_active_o=0.
  - Slot 2: wave toggles every 2 cycles.
  - done_o pulses once at cycle 48 after start; busy_o drops the same cycle.
- Same setup with loop=1:
  - note_idx_o runs 0,1,2,0,1,2 for ≥3 loops, each step 16 cycles.
  - done_o never asserts.
  - stop_i mid-note -> next cycle busy_o=0, wave_o=0, no done_o.
- During PLAY, wr_en_i to addr 0 with 7 -> ignored; after return to IDLE, table[0] still 4. Assert start_i mid-play -> idx sequence unaffected.
- note_len=0, last_idx=31, loop=0, table[k]=1 for all k:
  - Idx advances every cycle 0..31.
  - wave_o=0 throughout, since each note resets phase and lasts 1 cycle.
  - done_o after 32 cycles.
- start_i and stop_i both high in IDLE -> stays IDLE.
- rst_n_i low for 1 cycle mid-PLAY -> all outputs 0 and table cleared; a subsequent start plays all rests.

Source files
------------

// File: rtl/melody_player.sv
// Table-driven melody player: steps a writable divider table at a fixed
// slot length and renders each entry as a square wave (divider 0 = rest).
module melody_player #(
  parameter int BW    = 16,
  parameter int IDX_W = 5,
  parameter int LEN_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [BW-1:0]    wr_data_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic [IDX_W-1:0] last_idx_i,
  input  logic [LEN_W-1:0] note_len_i,
  output logic             wave_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] note_idx_o,
  output logic             note_active_o
);

  localparam int DEPTH = 2**IDX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state;
  logic [BW-1:0]    tbl [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] slot_cnt;
  logic [BW-1:0]    tone_cnt;
  logic             wave;
  logic             done;
  logic             loop_q;
  logic [IDX_W-1:0] last_q;
  logic [LEN_W-1:0] len_q;
  logic [BW-1:0]    cur_div;

  assign cur_div = tbl[idx];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        tbl[k] <= '0;
      end
      idx      <= '0;
      slot_cnt <= '0;
      tone_cnt <= '0;
      wave     <= 1'b0;
      done     <= 1'b0;
      loop_q   <= 1'b0;
      last_q   <= '0;
      len_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          wave <= 1'b0;
          if (wr_en_i) begin
            tbl[wr_addr_i] <= wr_data_i;
          end
          if (start_i && !stop_i) begin
            state    <= PLAY;
            loop_q   <= loop_i;
            last_q   <= last_idx_i;
            len_q    <= note_len_i;
            idx      <= '0;
            slot_cnt <= '0;
            tone_cnt <= '0;
          end
        end
        PLAY: begin
          if (stop_i) begin
            state    <= IDLE;
            wave     <= 1'b0;
            slot_cnt <= '0;
            tone_cnt <= '0;
          end else if (slot_cnt == len_q) begin
            // every note starts phase-aligned low
            slot_cnt <= '0;
            tone_cnt <= '0;
            wave     <= 1'b0;
            if (idx != last_q) begin
              idx <= idx + IDX_W'(1);
            end else if (loop_q) begin
              idx <= '0;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
              idx   <= '0;
            end
          end else begin
            slot_cnt <= slot_cnt + LEN_W'(1);
            if (cur_div == '0) begin
              wave     <= 1'b0;
              tone_cnt <= '0;
            end else if (tone_cnt == cur_div - BW'(1)) begin
              tone_cnt <= '0;
              wave     <= ~wave;
            end else begin
              tone_cnt <= tone_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wave_o        = wave;
  assign busy_o        = (state == PLAY);
  assign done_o        = done;
  assign note_idx_o    = idx;
  assign note_active_o = (state == PLAY) && (cur_div != '0);

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_melody_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [4:0]  last_idx = '0;
  logic [23:0] note_len = '0;
  logic        wave, busy, done, act;
  logic [4:0]  nidx;

  melody_player #(.BW(16), .IDX_W(5), .LEN_W(24)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .stop_i(stop), .loop_i(loop),
    .last_idx_i(last_idx), .note_len_i(note_len),
    .wave_o(wave), .busy_o(busy), .done_o(done),
    .note_idx_o(nidx), .note_active_o(act)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [8:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // packed as {idx, active, done, busy, wave}
  function automatic logic [8:0] pk(int i, bit a, bit d, bit b, bit w);
    logic [4:0] iv;
    iv = 5'(i);
    return {iv, a, d, b, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(string nm, logic [8:0] v);
    exp_t e;
    e.nm  = nm;
    e.val = v;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [8:0] got;
    exp_t       e;
    got = {nidx, act, done, busy, wave};
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (got !== e.val) begin
        n_err++;
        $display("FAIL %s: got idx=%0d act=%b done=%b busy=%b wave=%b, want idx=%0d act=%b done=%b busy=%b wave=%b",
                 e.nm, got[8:4], got[3], got[2], got[1], got[0],
                 e.val[8:4], e.val[3], e.val[2], e.val[1], e.val[0]);
      end
    end
  end

  task automatic wr(int a, int d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = 16'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic go(bit lp, int last, int len);
    start    = 1'b1;
    loop     = lp;
    last_idx = 5'(last);
    note_len = 24'(len);
    tick();
    start    = 1'b0;
  endtask

  // expected wave p cycles into a note with half-period d
  function automatic bit wv(int d, int p);
    if (d == 0) return 1'b0;
    return ((p / d) % 2) == 1;
  endfunction

  int divs[3] = '{4, 0, 2};

  initial begin
    int s, p;
    rst_n = 1'b0;
    tick();
    tick();
    expect_o("reset", pk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick();

    // one-shot 3-note melody
    wr(0, 4);
    wr(1, 0);
    wr(2, 2);
    go(0, 2, 15);
    expect_o("os_start", pk(0, 1, 0, 1, 0));
    for (int c = 1; c < 48; c++) begin
      tick();
      s = c / 16;
      p = c % 16;
      expect_o($sformatf("os_c%0d", c),
               pk(s, divs[s] != 0, 0, 1, wv(divs[s], p)));
    end
    tick();
    expect_o("os_done", pk(0, 0, 1, 0, 0));
    tick();
    expect_o("os_done_clr", pk(0, 0, 0, 0, 0));

    // loop mode, with ignored write and restart mid-play, then stop
    go(1, 2, 15);
    expect_o("lp_start", pk(0, 1, 0, 1, 0));
    for (int c = 1; c <= 9 * 16 + 5; c++) begin
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      s = (c / 16) % 3;
      p = c % 16;
      expect_o($sformatf("lp_c%0d", c),
               pk(s, divs[s] != 0, 0, 1, wv(divs[s], p)));
      if (c == 20) begin
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 16'd7;
        start   = 1'b1;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_o("lp_stop", pk(0, 1'b0, 0, 0, 0) | 9'h000);
    tick();
    expect_o("lp_stop_idle", pk(0, 0, 0, 0, 0));

    // table[0] must still be 4: single-note one-shot
    go(0, 0, 15);
    for (int c = 1; c < 16; c++) begin
      tick();
      expect_o($sformatf("keep_c%0d", c), pk(0, 1, 0, 1, wv(4, c)));
    end
    tick();
    expect_o("keep_done", pk(0, 0, 1, 0, 0));

    // full table, 1-cycle notes
    for (int k = 0; k < 32; k++) wr(k, 1);
    go(0, 31, 0);
    expect_o("full_start", pk(0, 1, 0, 1, 0));
    for (int c = 1; c < 32; c++) begin
      tick();
      expect_o($sformatf("full_c%0d", c), pk(c, 1, 0, 1, 0));
    end
    tick();
    expect_o("full_done", pk(0, 0, 1, 0, 0));
    tick();
    expect_o("full_done_clr", pk(0, 0, 0, 0, 0));

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    expect_o("ss_idle", pk(0, 0, 0, 0, 0));
    tick();
    expect_o("ss_idle2", pk(0, 0, 0, 0, 0));
    start = 1'b0;
    stop  = 1'b0;

    // reset mid-play clears table and outputs
    go(1, 31, 3);
    for (int c = 1; c <= 7; c++) begin
      tick();
      expect_o($sformatf("rp_c%0d", c), pk(c / 4, 1, 0, 1, (c % 4) % 2 == 1));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_o("rp_reset", pk(0, 0, 0, 0, 0));
    go(0, 3, 3);
    for (int c = 1; c < 16; c++) begin
      tick();
      expect_o($sformatf("rest_c%0d", c), pk(c / 4, 0, 0, 1, 0));
    end
    tick();
    expect_o("rest_done", pk(0, 0, 1, 0, 0));

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
